// File: rtl/otter_intr_pkg.sv
// Shared types and constants for the OTTER interrupt controller.
// The optional input synchronizer is selected with OTTER_INTR_SYNC_EN.
package otter_intr_pkg;

   localparam int NUM_SRC_DEFAULT     = 4;
   localparam int CSR_MSTATUS_MIE_BIT = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } intr_state_t;

endpackage

// File: rtl/intr_edge_sync.sv
// One interrupt source: optional 2-flop synchronizer followed by a
// rising-edge detector. Define OTTER_INTR_SYNC_EN to insert the synchronizer;
// otherwise the source is assumed to already be synchronous to clk.
module intr_edge_sync
   import otter_intr_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic src,
   output logic evt
);

`ifdef OTTER_INTR_SYNC_EN
   logic meta;
   logic sync;
   logic prev;

   // Two-stage synchronizer plus previous-value register for edge detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= src;
         sync <= meta;
         prev <= sync;
      end
   end

   assign evt = sync & ~prev;
`else
   logic prev;

   // Previous sample of the already-synchronous source
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev <= 1'b0;
      end else begin
         prev <= src;
      end
   end

   assign evt = src & ~prev;
`endif

endmodule

// File: rtl/otter_intr_ctrl.sv
// OTTER interrupt controller: latches edge events from NUM_SRC sources,
// masks them with irq_en and csr_mie, and hands the lowest-index ready
// source to the core through a request / taken / mret handshake.
// Build option: OTTER_INTR_SYNC_EN adds a 2-flop synchronizer per source.
module otter_intr_ctrl
   import otter_intr_pkg::*;
#(
   parameter int NUM_SRC = NUM_SRC_DEFAULT,
   parameter int ID_W    = $clog2(NUM_SRC)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic [NUM_SRC-1:0] irq_en,
   input  logic               csr_mie,
   input  logic               int_taken,
   input  logic               mret_exec,
   input  logic               pend_clr_we,
   input  logic [NUM_SRC-1:0] pend_clr,
   output logic               intr_req,
   output logic [ID_W-1:0]    intr_id,
   output logic [NUM_SRC-1:0] pending
);

   logic [NUM_SRC-1:0] evt;
   logic [NUM_SRC-1:0] pend_next;
   logic [ID_W-1:0]    winner;
   logic [ID_W-1:0]    id_next;
   logic               any_ready;
   logic               take;
   intr_state_t        state;
   intr_state_t        state_next;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      intr_edge_sync u_edge (
         .clk     (clk),
         .reset_n (reset_n),
         .src     (irq_src[g]),
         .evt     (evt[g])
      );
   end

   // Priority encoder: lowest index that is both pending and enabled wins
   always_comb begin
      winner    = '0;
      any_ready = 1'b0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (pending[i] && irq_en[i]) begin
            winner    = ID_W'(i);
            any_ready = 1'b1;
         end
      end
   end

   assign take = (state == REQ) && int_taken;

   // Pending update: taken and software clears first, new events override them
   always_comb begin
      pend_next = pending;
      if (take) begin
         pend_next[intr_id] = 1'b0;
      end
      if (pend_clr_we) begin
         pend_next = pend_next & ~pend_clr;
      end
      pend_next = pend_next | evt;
   end

   // Handshake FSM; a request is withdrawn as soon as its source stops qualifying
   always_comb begin
      state_next = state;
      id_next    = intr_id;
      case (state)
         IDLE: begin
            if (csr_mie && any_ready) begin
               state_next = REQ;
               id_next    = winner;
            end
         end
         REQ: begin
            if (int_taken) begin
               state_next = SERVICE;
            end else if (!csr_mie || !(pend_next[intr_id] && irq_en[intr_id])) begin
               state_next = IDLE;
            end
         end
         SERVICE: begin
            if (mret_exec) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State, id, request and pending registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         intr_id  <= '0;
         intr_req <= 1'b0;
         pending  <= '0;
      end else begin
         state    <= state_next;
         intr_id  <= id_next;
         intr_req <= (state_next == REQ);
         pending  <= pend_next;
      end
   end

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Testbench for otter_intr_ctrl: directed scenarios plus randomized traffic,
// checked cycle by cycle against a queue-based reference model.
// Honours OTTER_INTR_SYNC_EN to match the DUT's input latency.
module tb_otter_intr_ctrl;

   localparam int N    = 4;
   localparam int ID_W = 2;
`ifdef OTTER_INTR_SYNC_EN
   localparam int D = 2;
`else
   localparam int D = 0;
`endif

   logic            clk = 1'b0;
   logic            reset_n;
   logic [N-1:0]    irq_src;
   logic [N-1:0]    irq_en;
   logic            csr_mie;
   logic            int_taken;
   logic            mret_exec;
   logic            pend_clr_we;
   logic [N-1:0]    pend_clr;
   logic            intr_req;
   logic [ID_W-1:0] intr_id;
   logic [N-1:0]    pending;

   always #5 clk = ~clk;

   otter_intr_ctrl #(.NUM_SRC(N), .ID_W(ID_W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .irq_src     (irq_src),
      .irq_en      (irq_en),
      .csr_mie     (csr_mie),
      .int_taken   (int_taken),
      .mret_exec   (mret_exec),
      .pend_clr_we (pend_clr_we),
      .pend_clr    (pend_clr),
      .intr_req    (intr_req),
      .intr_id     (intr_id),
      .pending     (pending)
   );

   typedef struct packed {
      logic            req;
      logic [ID_W-1:0] id;
      logic [N-1:0]    pend;
   } obs_t;

   obs_t sbq[$];
   int   checks = 0;
   int   passes = 0;

   // Reference model: raw samples in a delay line, pending as a bit set,
   // and two flags describing whether a request or a service is in progress.
   logic [N-1:0] raw_hist[$];
   logic [N-1:0] m_pend;
   bit           m_req;
   bit           m_serv;
   int           m_id;

   function automatic int lowest(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic void clear_hist();
      raw_hist = {};
      for (int i = 0; i < D + 2; i++) raw_hist.push_back('0);
   endfunction

   function automatic void model_step();
      logic [N-1:0] ev;
      logic [N-1:0] nxt;
      bit           took;
      obs_t         o;
      if (!reset_n) begin
         m_pend = '0; m_req = 0; m_serv = 0; m_id = 0;
         clear_hist();
      end else begin
         raw_hist.push_front(irq_src);
         void'(raw_hist.pop_back());
         ev   = raw_hist[D] & ~raw_hist[D+1];
         took = m_req && int_taken;
         nxt  = m_pend;
         if (took) nxt[m_id] = 1'b0;
         if (pend_clr_we) nxt = nxt & ~pend_clr;
         nxt = nxt | ev;
         if (m_serv) begin
            if (mret_exec) m_serv = 0;
         end else if (m_req) begin
            if (took) begin
               m_req = 0; m_serv = 1;
            end else if (!csr_mie || !(nxt[m_id] && irq_en[m_id])) begin
               m_req = 0;
            end
         end else if (csr_mie && lowest(m_pend & irq_en) >= 0) begin
            m_req = 1;
            m_id  = lowest(m_pend & irq_en);
         end
         m_pend = nxt;
      end
      o.req  = m_req;
      o.id   = ID_W'(m_id);
      o.pend = m_pend;
      sbq.push_back(o);
   endfunction

   obs_t mon_e;
   obs_t mon_a;

   // Monitor: compare every presented output sample against the scoreboard
   always @(negedge clk) begin
      if (sbq.size() != 0) begin
         mon_e = sbq.pop_front();
         mon_a.req  = intr_req;
         mon_a.id   = intr_id;
         mon_a.pend = pending;
         checks++;
         if (mon_a === mon_e) passes++;
         else $display("FAIL scoreboard t=%0t got req=%0b id=%0d pend=%b expected req=%0b id=%0d pend=%b",
                       $time, mon_a.req, mon_a.id, mon_a.pend, mon_e.req, mon_e.id, mon_e.pend);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_take();
      int_taken = 1'b1; cycle(); int_taken = 1'b0;
   endtask

   task automatic pulse_mret();
      mret_exec = 1'b1; cycle(); mret_exec = 1'b0;
   endtask

   task automatic wait_req(input string name, input int max);
      int n = 0;
      while (!intr_req && n < max) begin
         cycle(); n++;
      end
      if (!intr_req) begin
         checks++;
         $display("FAIL %s: timeout waiting for intr_req got 0 expected 1", name);
      end
   endtask

   task automatic drain();
      pulse_mret();
      repeat (12) begin
         if (intr_req) begin
            pulse_take(); pulse_mret();
         end else begin
            cycle();
         end
      end
   endtask

   // Stimulus
   initial begin
      int n;
      logic [N-1:0] flip;
      clear_hist();
      reset_n = 1'b0; irq_src = '0; irq_en = '0; csr_mie = 1'b0;
      int_taken = 1'b0; mret_exec = 1'b0; pend_clr_we = 1'b0; pend_clr = '0;
      m_pend = '0; m_req = 0; m_serv = 0; m_id = 0;
      #2;
      repeat (3) cycle();
      chk("reset_req", 32'(intr_req), 32'd0);
      chk("reset_pend", 32'(pending), 32'd0);
      reset_n = 1'b1;
      repeat (3) cycle();

      // Single source with latency measurement
      irq_en = 4'b0100; csr_mie = 1'b1; irq_src[2] = 1'b1;
      n = 0;
      do begin cycle(); n++; end while (!intr_req && n < 10);
      chk("single_latency", 32'(n), 32'(D + 2));
      chk("single_id", 32'(intr_id), 32'd2);
      irq_src[2] = 1'b0;
      cycle();
      pulse_take();
      chk("single_taken_req", 32'(intr_req), 32'd0);
      chk("single_taken_pend", 32'(pending), 32'd0);
      repeat (2) cycle();
      pulse_mret();
      repeat (3) cycle();

      // Priority between simultaneous arrivals
      irq_en = 4'b1111; irq_src = 4'b1010; cycle(); irq_src = '0;
      wait_req("prio_first", 10);
      chk("prio_first_id", 32'(intr_id), 32'd1);
      pulse_take(); repeat (2) cycle(); pulse_mret();
      cycle();
      chk("prio_second_req", 32'(intr_req), 32'd1);
      chk("prio_second_id", 32'(intr_id), 32'd3);
      pulse_take(); pulse_mret(); repeat (3) cycle();

      // Global masking
      csr_mie = 1'b0; irq_src = 4'b0001; cycle(); irq_src = '0;
      repeat (D + 3) cycle();
      chk("mask_pend", 32'(pending), 32'd1);
      chk("mask_noreq", 32'(intr_req), 32'd0);
      csr_mie = 1'b1; cycle();
      chk("mask_req_on", 32'(intr_req), 32'd1);
      csr_mie = 1'b0; cycle();
      chk("mask_req_drop", 32'(intr_req), 32'd0);
      chk("mask_pend_kept", 32'(pending), 32'd1);
      csr_mie = 1'b1;
      drain();

      // New event on the same source as it is being taken
      for (int w = 0; w < 4; w++) begin
         irq_src[2] = 1'b1; cycle(); irq_src[2] = 1'b0;
         repeat (4) cycle();
         wait_req("coll_req", 10);
         irq_src[2] = 1'b1;
         repeat (w) cycle();
         pulse_take();
         if (w == D) chk("coll_pend_kept", 32'(pending[2]), 32'd1);
         repeat (3) cycle();
         irq_src[2] = 1'b0;
         pulse_mret();
         repeat (6) cycle();
         drain();
      end

      // Level-held source and software clear while requesting
      irq_en = 4'b0001; irq_src[0] = 1'b1;
      repeat (50) cycle();
      chk("level_req", 32'(intr_req), 32'd1);
      pend_clr_we = 1'b1; pend_clr = 4'b0001; cycle();
      pend_clr_we = 1'b0; pend_clr = '0;
      chk("swclr_req", 32'(intr_req), 32'd0);
      chk("swclr_pend", 32'(pending), 32'd0);
      repeat (5) cycle();
      chk("level_one_event", 32'(pending), 32'd0);
      irq_src[0] = 1'b0;
      repeat (3) cycle();

      // Asynchronous reset while servicing with another source pending
      irq_en = 4'b1111;
      irq_src[1] = 1'b1; cycle(); irq_src[1] = 1'b0;
      wait_req("rst_req", 10);
      pulse_take();
      irq_src[3] = 1'b1; cycle(); irq_src[3] = 1'b0;
      repeat (D + 2) cycle();
      reset_n = 1'b0;
      #1;
      chk("rst_async_req", 32'(intr_req), 32'd0);
      chk("rst_async_pend", 32'(pending), 32'd0);
      chk("rst_async_id", 32'(intr_id), 32'd0);
      repeat (2) cycle();
      reset_n = 1'b1;
      repeat (6) cycle();
      chk("rst_stays_idle", 32'(intr_req), 32'd0);

      // Randomized traffic against the reference model
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) flip[i] = ($urandom_range(0, 7) == 0);
         irq_src = irq_src ^ flip;
         if ($urandom_range(0, 31) == 0) irq_en = N'($urandom);
         csr_mie     = ($urandom_range(0, 9) != 0);
         int_taken   = intr_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
         mret_exec   = ($urandom_range(0, 9) == 0);
         pend_clr_we = ($urandom_range(0, 29) == 0);
         pend_clr    = N'($urandom);
         cycle();
      end
      irq_src = '0; int_taken = 1'b0; mret_exec = 1'b0; pend_clr_we = 1'b0;
      repeat (5) cycle();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/otter_intr_ctrl.md
# otter_intr_ctrl

Interrupt controller that schedules multiple external interrupt sources (buttons, game-tick timer, VGA frame strobe) onto the OTTER's single interrupt input. It synchronizes and edge-detects each source, latches pending events, applies a per-source enable mask and the global MIE bit from CSR mstatus[3], picks the highest-priority request, and runs a request/taken/mret handshake with the core's control FSM and CSR block so exactly one interrupt is in service at a time.

## Interface
Parameters:
- NUM_SRC, 4, number of interrupt sources (2..16)
- ID_W, $clog2(NUM_SRC), width of source id

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- irq_src  in  NUM_SRC  raw interrupt lines, rising edge = event
- irq_en  in  NUM_SRC  per-source enable mask (from MMIO register)
- csr_mie  in  1  global enable, driven from CSR mstatus bit 3
- int_taken  in  1  one-cycle pulse from core FSM: interrupt accepted, MEPC saved
- mret_exec  in  1  one-cycle pulse: mret executed, handler finished
- pend_clr_we  in  1  software write-1-to-clear strobe
- pend_clr  in  NUM_SRC  bits to clear when pend_clr_we=1
- intr_req  out  1  interrupt request to core FSM
- intr_id  out  ID_W  id of source being requested/serviced
- pending  out  NUM_SRC  current pending bits (MMIO readable)

## Operation
- Per source: optional 2-flop synchronizer, registered previous value, event = cur & ~prev.
- pending[i] set on event[i]; cleared by int_taken for the winning id, or by pend_clr_we & pend_clr[i]. Set beats clear in the same cycle.
- Masked-off events still latch into pending; they request once irq_en[i] goes high.
- Winner: lowest index i with pending[i] & irq_en[i].
- FSM (package enum): IDLE, REQ, SERVICE.
  - IDLE -> REQ when csr_mie=1 and any pending&irq_en; intr_id <= winner.
  - REQ: intr_req=1. int_taken -> SERVICE, clear pending[intr_id]. csr_mie=0 or intr_id's pending/enable gone (sw clear) -> IDLE without taking.
  - SERVICE: intr_req=0, intr_id held. mret_exec -> IDLE.
- int_taken in IDLE/SERVICE ignored; mret_exec outside SERVICE ignored.
- intr_id fixed while in REQ; a higher-priority arrival waits until next IDLE pass.

## Timing
- Reset values: intr_req=0, intr_id=0, pending=0, state=IDLE, sync/prev flops=0. Reset mid-service drops all pending and returns to IDLE asynchronously.
- intr_req, intr_id, pending are registered outputs (no comb path from inputs).
- With sync: irq_src rising sampled at edge k -> pending visible after edge k+2 -> intr_req after edge k+3.
- Without sync: pending after edge k, intr_req after edge k+1.
- int_taken at edge t: pending bit cleared and intr_req=0 after edge t.
- mret_exec at edge t: IDLE after t; if another request is ready, intr_req=1 after t+1 (one idle cycle minimum between services).
- Source held high generates exactly one event; re-arms only after a low sample.

## Configuration
- OTTER_INTR_SYNC_EN defined: 2-flop synchronizer per source, latency as above.
- Undefined: irq_src treated as already synchronous to clk; synchronizer removed, latency 2 cycles shorter.

## Structure
- Package otter_intr_pkg: intr_state_t enum (IDLE, REQ, SERVICE), default NUM_SRC constant, CSR_MSTATUS_MIE_BIT = 3.
- Sub-module intr_edge_sync: one source's synchronizer (under macro) + edge detector, instantiated NUM_SRC times via generate.
- Top holds pending vector, priority encoder, FSM.

## Test plan
- Reset: reset_n=0 mid-SERVICE -> intr_req=0, pending=0, intr_id=0 immediately; stays IDLE after release with no sources.
- Single source: irq_en=4'b0100, mie=1, pulse irq_src[2] -> intr_req=1 at k+3, intr_id=2; int_taken -> pending=0, intr_req=0; mret_exec -> IDLE.
- Priority: irq_src[3] and [1] rise same cycle, all enabled -> intr_id=1 first; after take+mret, intr_id=3 one cycle after return to IDLE.
- Masking: mie=0, pulse src[0] -> pending=4'b0001, intr_req stays 0; set mie=1 -> intr_req=1 next cycle; drop mie in REQ -> IDLE, pending kept.
- Collision: new edge on src[2] in same cycle as int_taken for id 2 -> pending[2] remains 1, re-requested after mret.
- Level hold/sw clear: hold src[0] high 50 cycles -> one event only; pend_clr_we with 4'b0001 in REQ -> intr_req drops, state IDLE.
